// File: rtl/dds_phase_ctrl.sv
// Phase sequencer for the sine ROM: modulo-TABLE_LEN fractional accumulator, start/stop/burst FSM, sample re-timing.
// Optional build macro DDS_PHASE_OFFSET_EN adds a latched phase offset input (cfg_offset).
module dds_phase_ctrl #(
    parameter int TABLE_LEN = 10000,
    parameter int PHASE_W   = 14,
    parameter int FRAC_W    = 8,
    parameter int STEP_W    = 22,
    parameter int CNT_W     = 16,
    parameter int DATA_W    = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [STEP_W-1:0]  cfg_step,
    input  logic [CNT_W-1:0]   cfg_cycles,
`ifdef DDS_PHASE_OFFSET_EN
    input  logic [PHASE_W-1:0] cfg_offset,
`endif
    input  logic               start,
    input  logic               stop,
    output logic [PHASE_W-1:0] phase,
    input  logic [DATA_W-1:0]  rom_value,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               busy,
    output logic               done
);
    localparam logic [STEP_W:0] LIMIT = (STEP_W+1)'(TABLE_LEN * (2 ** FRAC_W));

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [STEP_W-1:0]   r_acc;
    logic [STEP_W-1:0]   r_step;
    logic [CNT_W-1:0]    r_cycles;
    logic [CNT_W-1:0]    r_count;
    logic [PHASE_W-1:0]  r_phase;
    logic [DATA_W-1:0]   r_sample;
    logic                r_sample_valid;
    logic                r_done;

    logic [STEP_W:0]     w_sum;
    logic                w_wrap;
    logic                w_burst_end;
    logic [STEP_W-1:0]   w_acc_adv;
    logic [STEP_W-1:0]   w_cfg_step_sat;
    logic [CNT_W-1:0]    w_count_inc;
    logic [PHASE_W-1:0]  w_acc_int;
    logic [PHASE_W-1:0]  w_phase_run;
    logic [PHASE_W-1:0]  w_phase_first;

    // Sum is one bit wider than the accumulator so the wrap compare cannot overflow.
    assign w_sum          = {1'b0, r_acc} + {1'b0, r_step};
    assign w_wrap         = (w_sum >= LIMIT);
    assign w_acc_adv      = w_wrap ? STEP_W'(w_sum - LIMIT) : STEP_W'(w_sum);
    assign w_acc_int      = w_acc_adv[STEP_W-1:FRAC_W];
    assign w_count_inc    = r_count + CNT_W'(1);
    assign w_burst_end    = w_wrap && (r_cycles != '0) && (w_count_inc == r_cycles);
    assign w_cfg_step_sat = ({1'b0, cfg_step} >= LIMIT) ? STEP_W'(LIMIT - 1) : cfg_step;

`ifdef DDS_PHASE_OFFSET_EN
    localparam logic [PHASE_W:0] TLEN = (PHASE_W+1)'(TABLE_LEN);

    logic [PHASE_W-1:0]  r_offset;
    logic [PHASE_W-1:0]  w_cfg_offset_red;
    logic [PHASE_W:0]    w_phase_sum;

    assign w_cfg_offset_red = ({1'b0, cfg_offset} >= TLEN) ? PHASE_W'({1'b0, cfg_offset} - TLEN) : cfg_offset;
    assign w_phase_sum      = {1'b0, w_acc_int} + {1'b0, r_offset};
    assign w_phase_run      = (w_phase_sum >= TLEN) ? PHASE_W'(w_phase_sum - TLEN) : PHASE_W'(w_phase_sum);
    assign w_phase_first    = cfg_valid ? w_cfg_offset_red : r_offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_offset <= '0;
        end else if (r_state == ST_IDLE && cfg_valid) begin
            r_offset <= w_cfg_offset_red;
        end
    end
`else
    assign w_phase_run   = w_acc_int;
    assign w_phase_first = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_RUN;
            ST_RUN:   if (stop || w_burst_end) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE:  cfg_ready = 1'b1;
            ST_RUN:   busy = 1'b1;
            ST_DRAIN: busy = 1'b1;
            default:  cfg_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc          <= '0;
            r_step         <= '0;
            r_cycles       <= '0;
            r_count        <= '0;
            r_phase        <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            // Every RUN cycle presents a phase, so its ROM word is captured on the following edge.
            r_sample_valid <= (r_state == ST_RUN);
            r_done         <= (r_state == ST_RUN) && (w_state_next == ST_DRAIN);
            if (r_state == ST_RUN) begin
                r_sample <= rom_value;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        r_step   <= w_cfg_step_sat;
                        r_cycles <= cfg_cycles;
                    end
                    if (start) begin
                        r_acc   <= '0;
                        r_count <= '0;
                        r_phase <= w_phase_first;
                    end else begin
                        r_phase <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_adv;
                    if (w_wrap) begin
                        r_count <= w_count_inc;
                    end
                    // The wrapped phase at burst end is never shown.
                    r_phase <= (w_state_next == ST_RUN) ? w_phase_run : '0;
                end
                default: r_phase <= '0;
            endcase
        end
    end

    assign phase        = r_phase;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign done         = r_done;
endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Self-checking bench for dds_phase_ctrl: closed-form phase/sample trace model plus per-cycle compare.
// Offset scenarios are built only when DDS_PHASE_OFFSET_EN is defined.
module tb_dds_phase_ctrl;
    localparam int     TABLE_LEN = 10000;
    localparam int     PHASE_W   = 14;
    localparam int     FRAC_W    = 8;
    localparam int     STEP_W    = 22;
    localparam int     CNT_W     = 16;
    localparam int     DATA_W    = 12;
    localparam longint LIMIT     = longint'(TABLE_LEN) * (64'd1 << FRAC_W);

    logic               clk;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [STEP_W-1:0]  cfg_step;
    logic [CNT_W-1:0]   cfg_cycles;
`ifdef DDS_PHASE_OFFSET_EN
    logic [PHASE_W-1:0] cfg_offset;
`endif
    logic               start;
    logic               stop;
    logic [PHASE_W-1:0] phase;
    logic [DATA_W-1:0]  rom_value;
    logic [DATA_W-1:0]  sample;
    logic               sample_valid;
    logic               busy;
    logic               done;

    dds_phase_ctrl dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_step(cfg_step), .cfg_cycles(cfg_cycles),
`ifdef DDS_PHASE_OFFSET_EN
        .cfg_offset(cfg_offset),
`endif
        .start(start), .stop(stop), .phase(phase), .rom_value(rom_value),
        .sample(sample), .sample_valid(sample_valid), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rom_f(input int p);
        return (p * 3 + 5) % 4096;
    endfunction

    assign rom_value = DATA_W'(rom_f(int'(phase)));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle outputs for run/drain cycles; cycles absent from the map must look idle.
    int e_busy[int];
    int e_phase[int];
    int e_valid[int];
    int e_sample[int];
    int e_done[int];
    int hold_prev = 0, hold_val = 0, hold_from = 0;
    bit model_en = 0;
    longint m_s = 0;
    int m_n = 0, m_off = 0;

    int seen_phase[$];
    int n_valid = 0, n_done = 0, done_sample = -1;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    function automatic int seen_at(input int i);
        if (i < seen_phase.size()) return seen_phase[i];
        return -1;
    endfunction

    // Phase of the j-th presented sample: integer part of j*S modulo the table, plus offset.
    function automatic int ph(input longint s, input int off, input int j);
        longint a;
        a = (longint'(j) * s) % LIMIT;
        return (int'(a >> FRAC_W) + off) % TABLE_LEN;
    endfunction

    always @(negedge clk) begin
        if (model_en) begin
            if (e_busy.exists(cyc)) begin
                chk("busy", busy, e_busy[cyc]);
                chk("cfg_ready", cfg_ready, 0);
                if (e_phase[cyc] >= 0) begin
                    chk("phase", phase, e_phase[cyc]);
                    seen_phase.push_back(int'(phase));
                end
                chk("sample_valid", sample_valid, e_valid[cyc]);
                chk("sample", sample, e_sample[cyc]);
                chk("done", done, e_done[cyc]);
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_cfg_ready", cfg_ready, 1);
                chk("idle_phase", phase, 0);
                chk("idle_valid", sample_valid, 0);
                chk("idle_done", done, 0);
                chk("idle_sample_hold", sample, (cyc >= hold_from) ? hold_val : hold_prev);
            end
            chk("phase_range", (phase < PHASE_W'(TABLE_LEN)) ? 1 : 0, 1);
            if (sample_valid) n_valid++;
            if (done) begin
                n_done++;
                done_sample = int'(sample);
            end
        end
    end

    task automatic plan(input int c0, input int stop_len, input int rst_at, output int len);
        int lb, shown, c, cur_hold;
        lb = 1 << 30;
        if (m_n != 0 && m_s != 0) begin
            lb = 1;
            while ((longint'(lb) * m_s) / LIMIT < longint'(m_n)) lb++;
        end
        len = lb;
        if (stop_len > 0 && stop_len < len) len = stop_len;
        shown = (rst_at > 0) ? rst_at : len;
        cur_hold = (c0 >= hold_from) ? hold_val : hold_prev;
        for (int j = 0; j < shown; j++) begin
            c = c0 + 1 + j;
            e_busy[c]  = 1;
            e_phase[c] = ph(m_s, m_off, j);
            e_done[c]  = 0;
            e_valid[c] = (j == 0) ? 0 : 1;
            e_sample[c] = (j == 0) ? cur_hold : rom_f(ph(m_s, m_off, j - 1));
        end
        hold_prev = cur_hold;
        if (rst_at > 0) begin
            hold_val  = 0;
            hold_from = c0 + rst_at + 1;
        end else begin
            c = c0 + len + 1;
            e_busy[c]   = 1;
            e_phase[c]  = -1;
            e_valid[c]  = 1;
            e_done[c]   = 1;
            e_sample[c] = rom_f(ph(m_s, m_off, len - 1));
            hold_val    = e_sample[c];
            hold_from   = c0 + len + 2;
        end
    endtask

    task automatic drive_cfg(input longint step, input int cycles, input int off);
        cfg_valid  = 1'b1;
        cfg_step   = STEP_W'(step);
        cfg_cycles = CNT_W'(cycles);
        m_s = (step >= LIMIT) ? LIMIT - 1 : step;
        m_n = cycles;
`ifdef DDS_PHASE_OFFSET_EN
        cfg_offset = PHASE_W'(off);
        m_off = (off >= TABLE_LEN) ? off - TABLE_LEN : off;
`else
        if (off != 0) $display("note: offset %0d ignored in this build", off);
        m_off = 0;
`endif
    endtask

    task automatic cfg(input longint step, input int cycles, input int off);
        @(posedge clk); #1;
        drive_cfg(step, cycles, off);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic run(input bit with_cfg, input longint step, input int cycles, input int off,
                       input int stop_len, input int rst_at, input string tag);
        int c0, len, last, shown;
        @(posedge clk); #1;
        c0 = cyc;
        if (with_cfg) drive_cfg(step, cycles, off);
        start = 1'b1;
        plan(c0, stop_len, rst_at, len);
        seen_phase.delete();
        n_valid = 0;
        n_done = 0;
        done_sample = -1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_valid = 1'b0;
        shown = (rst_at > 0) ? rst_at : len;
        last = (rst_at > 0) ? rst_at : len + 2;
        for (int k = 1; k <= last; k++) begin
            stop = (stop_len > 0 && k == stop_len);
            cfg_valid = (k == 2 && k < shown);
            if (k == 2) begin
                cfg_step = STEP_W'(777);
                cfg_cycles = CNT_W'(5);
`ifdef DDS_PHASE_OFFSET_EN
                cfg_offset = PHASE_W'(1);
`endif
            end
            start = (k == 3 && k < shown);
            rst = (rst_at > 0 && k == rst_at);
            @(posedge clk); #1;
        end
        stop = 1'b0;
        cfg_valid = 1'b0;
        start = 1'b0;
        rst = 1'b0;
        if (rst_at > 0) begin
            m_s = 0;
            m_n = 0;
            m_off = 0;
        end
        $display("run %s: len=%0d phases=%0d samples=%0d dones=%0d last_sample=%0d",
                 tag, len, seen_phase.size(), n_valid, n_done, done_sample);
    endtask

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_step = '0;
        cfg_cycles = '0;
`ifdef DDS_PHASE_OFFSET_EN
        cfg_offset = '0;
`endif
        start = 1'b0;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_phase", phase, 0);
        chk("reset_sample", sample, 0);
        chk("reset_valid", sample_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_cfg_ready", cfg_ready, 1);
        model_en = 1;

        // Two-period burst at integer step 100; stop in IDLE must be ignored.
        cfg(64'd25600, 2, 0);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        run(0, 0, 0, 0, 0, 0, "burst2");
        chk("burst_samples", n_valid, 200);
        chk("burst_phases", seen_phase.size(), 200);
        chk("burst_dones", n_done, 1);
        chk("burst_done_sample", done_sample, 1033);
        chk("burst_ph1", seen_at(1), 100);
        chk("burst_ph100", seen_at(100), 0);
        chk("burst_ph199", seen_at(199), 9900);

        // Oversized step saturates to LIMIT-1: phase walks down from 9999.
        cfg(64'd2560005, 0, 0);
        run(0, 0, 0, 0, 300, 0, "saturate");
        chk("sat_ph1", seen_at(1), 9999);
        chk("sat_ph256", seen_at(256), 9999);
        chk("sat_ph257", seen_at(257), 9998);
        chk("sat_samples", n_valid, 300);

        // Continuous run stopped after 37 phases.
        cfg(64'd256, 0, 0);
        run(0, 0, 0, 0, 37, 0, "stop37");
        chk("stop_samples", n_valid, 37);
        chk("stop_ph36", seen_at(36), 36);
        chk("stop_done_sample", done_sample, 113);

        // Config and start together, then a config offered during RUN must be ignored.
        run(1, 64'd512, 0, 0, 10, 0, "cfg_start");
        chk("cs_ph0", seen_at(0), 0);
        chk("cs_ph1", seen_at(1), 2);
        chk("cs_ph2", seen_at(2), 4);
        run(0, 0, 0, 0, 4, 0, "step_kept");
        chk("kept_ph1", seen_at(1), 2);

        // Stop coinciding with burst end gives one drain.
        cfg(64'd25600, 1, 0);
        run(0, 0, 0, 0, 100, 0, "stop_at_end");
        chk("sae_dones", n_done, 1);
        chk("sae_samples", n_valid, 100);

        // Reset mid-run aborts; config registers return to zero.
        cfg(64'd256, 0, 0);
        run(0, 0, 0, 0, 0, 20, "reset_mid");
        chk("rm_dones", n_done, 0);
        chk("rm_busy_after", busy, 0);
        chk("rm_valid_after", sample_valid, 0);
        chk("rm_phase_after", phase, 0);
        run(0, 0, 0, 0, 5, 0, "after_reset_step0");
        chk("ar_ph4", seen_at(4), 0);
        chk("ar_samples", n_valid, 5);
        run(1, 64'd256, 0, 0, 3, 0, "restart");
        chk("rs_ph2", seen_at(2), 2);

`ifdef DDS_PHASE_OFFSET_EN
        cfg(64'd25600, 0, 9950);
        run(0, 0, 0, 0, 5, 0, "offset9950");
        chk("off_ph0", seen_at(0), 9950);
        chk("off_ph1", seen_at(1), 50);
        chk("off_ph2", seen_at(2), 150);
        cfg(64'd25600, 0, 10003);
        run(0, 0, 0, 0, 3, 0, "offset10003");
        chk("off2_ph0", seen_at(0), 3);
        chk("off2_ph1", seen_at(1), 103);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
